// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the word serializer.
package ser_pkg;

  typedef enum logic {StIdle, StShift} state_t;

  // Counter width able to hold WIDTH-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Handshake and serial-stream bundle for word_serializer.
interface word_serializer_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             serial_o;
  logic             bit_valid_o;
  logic             first_o;
  logic             last_o;
  logic             busy_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, serial_o, bit_valid_o, first_o, last_o, busy_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, serial_o, bit_valid_o, first_o, last_o, busy_o
  );

endinterface

// File: rtl/ser_bit_counter.sv
// Loadable down-counter for bit position; flags the first (full) and last (zero) bit.
module ser_bit_counter
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero,
  output logic full
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] MaxVal = CntW'(WIDTH - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= MaxVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);
  assign full = (cnt_q == MaxVal);

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end with first/last framing; LSB-first order when
// SER_LSB_FIRST_EN is defined, MSB-first otherwise.
module word_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  word_serializer_if.slave    bus
);

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shifted;
  logic             serial;
  logic             in_shift;
  logic             cnt_zero;
  logic             cnt_full;
  logic             last_bit;
  logic             first_bit;
  logic             ready;
  logic             hs;

  assign in_shift  = (state_q == StShift);
  assign last_bit  = in_shift && cnt_zero;
  assign first_bit = in_shift && cnt_full;
  // Accepting on the final bit lets the next word follow with no bubble.
  assign ready     = !in_shift || last_bit;
  assign hs        = bus.valid_i && ready;

`ifdef SER_LSB_FIRST_EN
  assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
  assign serial  = shreg_q[0];
`else
  assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
  assign serial  = shreg_q[WIDTH-1];
`endif

  ser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hs),
    .dec   (in_shift),
    .zero  (cnt_zero),
    .full  (cnt_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs) begin
            state_q <= StShift;
            shreg_q <= bus.data_i;
          end
        end
        StShift: begin
          if (hs) begin
            shreg_q <= bus.data_i;
          end else begin
            // Shifting out the last bit leaves the register empty for IDLE.
            shreg_q <= shifted;
            if (cnt_zero) state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.ready_o     = ready;
  assign bus.serial_o    = serial;
  assign bus.bit_valid_o = in_shift;
  assign bus.first_o     = first_bit;
  assign bus.last_o      = last_bit;
  assign bus.busy_o      = in_shift;

endmodule
